// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: states, opcodes, functs and mux selects.
// MIPS_CTRL_IMM_LOGIC_EN adds the IMMEX state for andi/ori/xori.
package mips_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_RTYPEEX = 4'd6,
      S_RTYPEWB = 4'd7,
      S_BEQEX   = 4'd8,
      S_ADDIEX  = 4'd9,
      S_ADDIWB  = 4'd10,
`ifdef MIPS_CTRL_IMM_LOGIC_EN
      S_JEX     = 4'd11,
      S_IMMEX   = 4'd12
`else
      S_JEX     = 4'd11
`endif
   } state_e;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_XORI  = 6'b001110;

   localparam logic [5:0] FUNCT_ADD = 6'b100000;
   localparam logic [5:0] FUNCT_SUB = 6'b100010;
   localparam logic [5:0] FUNCT_AND = 6'b100100;
   localparam logic [5:0] FUNCT_OR  = 6'b100101;
   localparam logic [5:0] FUNCT_XOR = 6'b100110;
   localparam logic [5:0] FUNCT_NOR = 6'b100111;
   localparam logic [5:0] FUNCT_SLT = 6'b101010;

   localparam logic [3:0] ALUOP_ADD = 4'b0000;
   localparam logic [3:0] ALUOP_SUB = 4'b0010;
   localparam logic [3:0] ALUOP_AND = 4'b0100;
   localparam logic [3:0] ALUOP_OR  = 4'b0101;
   localparam logic [3:0] ALUOP_XOR = 4'b0110;
   localparam logic [3:0] ALUOP_NOR = 4'b0111;
   localparam logic [3:0] ALUOP_SLT = 4'b1010;

   localparam logic [1:0] SRCB_B       = 2'b00;
   localparam logic [1:0] SRCB_FOUR    = 2'b01;
   localparam logic [1:0] SRCB_IMM     = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// R-type funct field to ALU opcode decoder; funct_valid flags unsupported functs.
module alu_decoder
   import mips_ctrl_pkg::*;
(
   input  logic [5:0] funct,
   output logic [3:0] alu_op,
   output logic       funct_valid
);

   always_comb begin
      alu_op      = ALUOP_ADD;
      funct_valid = 1'b1;
      case (funct)
         FUNCT_ADD: alu_op = ALUOP_ADD;
         FUNCT_SUB: alu_op = ALUOP_SUB;
         FUNCT_AND: alu_op = ALUOP_AND;
         FUNCT_OR:  alu_op = ALUOP_OR;
         FUNCT_XOR: alu_op = ALUOP_XOR;
         FUNCT_NOR: alu_op = ALUOP_NOR;
         FUNCT_SLT: alu_op = ALUOP_SLT;
         default:   funct_valid = 1'b0;
      endcase
   end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control unit: Moore FSM driving ALU opcode and datapath enables.
// MIPS_CTRL_IMM_LOGIC_EN adds andi/ori/xori (IMMEX state) and the ExtZero output.
module mips_multicycle_ctrl
   import mips_ctrl_pkg::*;
#(
   parameter int unsigned STATE_W = 4
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic [5:0]         Op,
   input  logic [5:0]         Funct,
   input  logic               Zero,
   output logic [3:0]         ALUOp,
   output logic               ALUSrcA,
   output logic [1:0]         ALUSrcB,
   output logic               IorD,
   output logic               IRWrite,
   output logic               MemWrite,
   output logic               RegDst,
   output logic               MemtoReg,
   output logic               RegWrite,
   output logic [1:0]         PCSrc,
   output logic               PCEn,
   output logic               IllegalOp,
`ifdef MIPS_CTRL_IMM_LOGIC_EN
   output logic               ExtZero,
`endif
   output logic [STATE_W-1:0] State
);

   state_e     state_q, state_d;
   logic [3:0] dec_alu_op;
   logic       dec_funct_valid;
   logic       ir_write, mem_write, reg_write, pc_en, illegal;
`ifdef MIPS_CTRL_IMM_LOGIC_EN
   logic       ext_zero;
`endif

   alu_decoder u_alu_decoder (
      .funct       (Funct),
      .alu_op      (dec_alu_op),
      .funct_valid (dec_funct_valid)
   );

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) state_q <= S_FETCH;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d   = S_FETCH;
      ALUOp     = ALUOP_ADD;
      ALUSrcA   = 1'b0;
      ALUSrcB   = SRCB_B;
      IorD      = 1'b0;
      RegDst    = 1'b0;
      MemtoReg  = 1'b0;
      PCSrc     = PCSRC_ALU;
      ir_write  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
      pc_en     = 1'b0;
      illegal   = 1'b0;
`ifdef MIPS_CTRL_IMM_LOGIC_EN
      ext_zero  = 1'b0;
`endif
      case (state_q)
         S_FETCH: begin
            ALUSrcB  = SRCB_FOUR;
            ir_write = 1'b1;
            pc_en    = 1'b1;
            state_d  = S_DECODE;
         end
         S_DECODE: begin
            ALUSrcB = SRCB_IMM_SH2;
            case (Op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYPE:     state_d = S_RTYPEEX;
               OP_BEQ:       state_d = S_BEQEX;
               OP_ADDI:      state_d = S_ADDIEX;
               OP_J:         state_d = S_JEX;
`ifdef MIPS_CTRL_IMM_LOGIC_EN
               OP_ANDI, OP_ORI, OP_XORI: state_d = S_IMMEX;
`endif
               default:      illegal = 1'b1;
            endcase
         end
         S_MEMADR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = SRCB_IMM;
            state_d = (Op == OP_SW) ? S_MEMWR : S_MEMRD;
         end
         S_MEMRD: begin
            IorD    = 1'b1;
            state_d = S_MEMWB;
         end
         S_MEMWB: begin
            MemtoReg  = 1'b1;
            reg_write = 1'b1;
         end
         S_MEMWR: begin
            IorD      = 1'b1;
            mem_write = 1'b1;
         end
         S_RTYPEEX: begin
            ALUSrcA = 1'b1;
            ALUOp   = dec_alu_op;
            // An unsupported funct aborts straight back to FETCH so no writeback happens.
            if (dec_funct_valid) state_d = S_RTYPEWB;
            else                 illegal = 1'b1;
         end
         S_RTYPEWB: begin
            RegDst    = 1'b1;
            reg_write = 1'b1;
         end
         S_BEQEX: begin
            ALUSrcA = 1'b1;
            ALUOp   = ALUOP_SUB;
            PCSrc   = PCSRC_ALUOUT;
            pc_en   = Zero;
         end
         S_ADDIEX: begin
            ALUSrcA = 1'b1;
            ALUSrcB = SRCB_IMM;
            state_d = S_ADDIWB;
         end
         S_ADDIWB: begin
            reg_write = 1'b1;
         end
         S_JEX: begin
            PCSrc = PCSRC_JUMP;
            pc_en = 1'b1;
         end
`ifdef MIPS_CTRL_IMM_LOGIC_EN
         S_IMMEX: begin
            ALUSrcA  = 1'b1;
            ALUSrcB  = SRCB_IMM;
            ext_zero = 1'b1;
            case (Op)
               OP_ANDI: ALUOp = ALUOP_AND;
               OP_ORI:  ALUOp = ALUOP_OR;
               default: ALUOp = ALUOP_XOR;
            endcase
            state_d = S_ADDIWB;
         end
`endif
         default: state_d = S_FETCH;
      endcase
   end

   // Write strobes are masked by reset so an aborted instruction commits nothing.
   assign IRWrite   = ir_write  & RST;
   assign MemWrite  = mem_write & RST;
   assign RegWrite  = reg_write & RST;
   assign PCEn      = pc_en     & RST;
   assign IllegalOp = illegal   & RST;
`ifdef MIPS_CTRL_IMM_LOGIC_EN
   assign ExtZero   = ext_zero;
`endif
   assign State     = STATE_W'(state_q);

endmodule
